fifo_uart_tx: RTL

Downstream consumer for the asynchronous nibble FIFO. It runs on the FIFO read-side clock and pops 4-bit entries through the FIFO's read-enable/empty interface. It packs each pair of nibbles into one byte, low nibble first, and sends the byte on a UART 8N1 serial line. This turns the FIFO's parallel nibble output into a single-pin stream for the board.

---
 rtl/fifo_uart_tx.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
// Pops nibble pairs from the async FIFO read port and sends each pair as one UART 8N1 byte,
// first nibble in bits [3:0].
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    input  logic [3:0] fifo_data,
    output logic       fifo_re,
    output logic       tx,
    output logic       busy,
    output logic [7:0] frames_sent
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCapLo,
        StNeedHi,
        StCapHi,
        StStart,
        StData,
        StStop
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [3:0]      lo_q, lo_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic [7:0]      frames_q, frames_d;
    logic            cnt_done;

    assign cnt_done    = (cnt_q == CntMax);
    assign fifo_re     = ((state_q == StIdle) || (state_q == StNeedHi)) && !fifo_empty && !rst;
    assign busy        = (state_q != StIdle);
    assign tx          = tx_q;
    assign frames_sent = frames_q;

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        lo_d     = lo_q;
        shift_d  = shift_q;
        tx_d     = 1'b1;
        frames_d = frames_q;
        cnt_d    = '0;

        unique case (state_q)
            StIdle: begin
                if (fifo_re) state_d = StCapLo;
            end
            StCapLo: begin
                lo_d    = fifo_data;
                state_d = StNeedHi;
            end
            StNeedHi: begin
                if (fifo_re) state_d = StCapHi;
            end
            StCapHi: begin
                shift_d = {fifo_data, lo_q};
                tx_d    = 1'b0;
                state_d = StStart;
            end
            StStart: begin
                tx_d = 1'b0;
                if (cnt_done) begin
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    state_d = StData;
                end
            end
            StData: begin
                // tx is registered, so drive the value for the coming cycle.
                tx_d = shift_q[bit_q];
                if (cnt_done) begin
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[bit_q + 3'd1];
                    end
                end
            end
            StStop: begin
                if (cnt_done) begin
                    frames_d = frames_q + 8'd1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if ((state_q == StStart) || (state_q == StData) || (state_q == StStop)) begin
            cnt_d = (cnt_done || (state_d != state_q)) ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bit_q    <= 3'd0;
            lo_q     <= 4'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
            frames_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            lo_q     <= lo_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            frames_q <= frames_d;
        end
    end

endmodule
